// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared constants, fetch FSM encodings and PC helper for the IF stage
package if_fetch_stage_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_REQ  = 2'b00,
    IF_HOLD = 2'b01,
    IF_DROP = 2'b10
  } if_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// rtl/if_fetch_stage_if_id_reg.sv - IF/ID pipeline register with flush/load/bubble/hold
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // Priority: flush > load > bubble > hold. Bubble keeps pc so only valid/inst move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (flush) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (bubble) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch FSM, PC, one-entry skid buffer and IF/ID register
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  if_state_e   state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;

  logic        accept;
  logic        ack;
  logic [31:0] pc_next;
  logic [31:0] redirect_target;
  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_pc_d;
  logic [31:0] ifid_inst_d;

  assign accept          = !id_valid_o || !stall_i;
  assign imem_req_o      = (state != IF_HOLD) && !rst_i;
  assign imem_addr_o     = req_addr;
  assign ack             = imem_ack_i && (state != IF_HOLD);
  assign pc_next         = pc + 32'd4;
  assign redirect_target = align_pc(redirect_pc_i);

  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_pc_d   = req_addr;
    ifid_inst_d = imem_rdata_i;
    if (!redirect_i && accept) begin
      case (state)
        IF_REQ: begin
          if (ack) ifid_load = 1'b1;
          else     ifid_bubble = 1'b1;
        end
        IF_HOLD: begin
          ifid_load   = 1'b1;
          ifid_pc_d   = buf_pc;
          ifid_inst_d = buf_inst;
        end
        default: ifid_bubble = 1'b1;
      endcase
    end
  end

  // In REQ pc always equals req_addr; DROP is the only state where they differ.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IF_REQ;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      buf_pc   <= '0;
      buf_inst <= '0;
    end else if (redirect_i) begin
      pc <= redirect_target;
      case (state)
        IF_REQ: begin
          if (ack) req_addr <= redirect_target;
          else     state    <= IF_DROP;
        end
        IF_HOLD: begin
          req_addr <= redirect_target;
          state    <= IF_REQ;
        end
        default: state <= IF_DROP;
      endcase
    end else begin
      case (state)
        IF_REQ: begin
          if (ack) begin
            pc       <= pc_next;
            req_addr <= pc_next;
            if (!accept) begin
              buf_pc   <= req_addr;
              buf_inst <= imem_rdata_i;
              state    <= IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (accept) state <= IF_REQ;
        end
        IF_DROP: begin
          if (ack) begin
            req_addr <= pc;
            state    <= IF_REQ;
          end
        end
        default: state <= IF_REQ;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (redirect_i),
    .load      (ifid_load),
    .bubble    (ifid_bubble),
    .load_pc   (ifid_pc_d),
    .load_inst (ifid_inst_d),
    .valid     (id_valid_o),
    .pc        (id_pc_o),
    .inst      (id_inst_o)
  );

endmodule
